// File: rtl/stp_frame_if.sv
// stp_frame_if: sample input, frame output handshake and overflow flag of the framer
//  master: producer/consumer side (drives fir_*, frm_ready, clr_ovf)
//  slave : framer side (drives frm_valid, frm_data, ovf)
interface stp_frame_if #(parameter int DW = 16, parameter int OW = 32, parameter int N = 16);
  logic fir_valid;
  logic [DW-1:0] fir_d;
  logic frm_ready;
  logic clr_ovf;
  logic frm_valid;
  logic [N*OW-1:0] frm_data;
  logic ovf;
  modport master(output fir_valid, fir_d, frm_ready, clr_ovf, input frm_valid, frm_data, ovf);
  modport slave(input fir_valid, fir_d, frm_ready, clr_ovf, output frm_valid, frm_data, ovf);
endinterface

// File: rtl/stp_frame.sv
// stp_frame: serial-to-parallel framer, N sign-extended lanes with hop/overlap and optional bit-reversed lanes
//  CLK, RST_N (async, active low)
//  bus.fir_valid/fir_d in; bus.frm_valid/frm_data/frm_ready frame handshake; bus.ovf sticky drop flag, bus.clr_ovf clears it
module stp_frame #(
  parameter int DW = 16,
  parameter int OW = 32,
  parameter int N = 16,
  parameter int HOP = 16,
  parameter bit FLUSH_ON_GAP = 1'b1,
  parameter bit BITREV = 1'b0
) (
  input logic CLK,
  input logic RST_N,
  stp_frame_if.slave bus
);
  localparam int LG = $clog2(N);
  localparam int CW = $clog2(N + 1);
  logic [DW-1:0] win [N];
  logic [DW-1:0] nwin [N];
  logic [CW-1:0] fill_cnt, hop_cnt;
  logic first, done, load;
  logic [N*OW-1:0] frame;
  function automatic logic [LG-1:0] rev(input logic [LG-1:0] x);
    for (int b = 0; b < LG; b++) rev[b] = x[LG-1-b];
  endfunction
  always_comb begin
    for (int i = 0; i < N - 1; i++) nwin[i] = win[i+1];
    nwin[N-1] = bus.fir_d;
  end
  // frame is built from the post-shift window so the completing sample bypasses straight into its lane
  always_comb begin
    frame = '0;
    for (int i = 0; i < N; i++) frame[(BITREV ? int'(rev(LG'(i))) : i)*OW +: OW] = OW'($signed(nwin[i]));
  end
  assign done = bus.fir_valid & ((first & (fill_cnt == CW'(N - 1))) | ((fill_cnt == CW'(N)) & (hop_cnt == CW'(HOP - 1))));
  assign load = done & (~bus.frm_valid | bus.frm_ready);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      fill_cnt <= '0;
      hop_cnt <= '0;
      first <= 1'b1;
      bus.frm_valid <= 1'b0;
      bus.frm_data <= '0;
      bus.ovf <= 1'b0;
    end else begin
      if (bus.fir_valid) begin
        for (int i = 0; i < N; i++) win[i] <= nwin[i];
        fill_cnt <= (fill_cnt == CW'(N)) ? fill_cnt : fill_cnt + CW'(1);
        // restart the hop phase at every frame so each later frame carries exactly HOP new samples
        hop_cnt <= (done || hop_cnt == CW'(HOP - 1)) ? '0 : hop_cnt + CW'(1);
        if (done) first <= 1'b0;
      end else if (FLUSH_ON_GAP) begin
        fill_cnt <= '0;
        hop_cnt <= '0;
        first <= 1'b1;
      end
      bus.frm_valid <= load | (bus.frm_valid & ~bus.frm_ready);
      if (load) bus.frm_data <= frame;
      bus.ovf <= (done & ~load) | (bus.ovf & ~bus.clr_ovf);
    end
  end
endmodule

// File: tb/tb_stp_frame.sv
// tb_stp_frame: four framer configurations on shared stimulus, table vectors, hand sequences and a random run against a sample-count model
module tb_stp_frame;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v = 1'b0, r = 1'b0, c = 1'b0;
  logic [15:0] d = '0;
  always #5 clk = ~clk;
  stp_frame_if #(.DW(16), .OW(32), .N(16)) b0(), b1(), b2();
  stp_frame_if #(.DW(16), .OW(32), .N(8)) b3();
  assign {b0.fir_valid, b0.fir_d, b0.frm_ready, b0.clr_ovf} = {v, d, r, c};
  assign {b1.fir_valid, b1.fir_d, b1.frm_ready, b1.clr_ovf} = {v, d, r, c};
  assign {b2.fir_valid, b2.fir_d, b2.frm_ready, b2.clr_ovf} = {v, d, r, c};
  assign {b3.fir_valid, b3.fir_d, b3.frm_ready, b3.clr_ovf} = {v, d, r, c};
  stp_frame #(.DW(16), .OW(32), .N(16), .HOP(16), .FLUSH_ON_GAP(1'b1), .BITREV(1'b0)) u0(.CLK(clk), .RST_N(rst_n), .bus(b0));
  stp_frame #(.DW(16), .OW(32), .N(16), .HOP(8), .FLUSH_ON_GAP(1'b1), .BITREV(1'b0)) u1(.CLK(clk), .RST_N(rst_n), .bus(b1));
  stp_frame #(.DW(16), .OW(32), .N(16), .HOP(16), .FLUSH_ON_GAP(1'b0), .BITREV(1'b0)) u2(.CLK(clk), .RST_N(rst_n), .bus(b2));
  stp_frame #(.DW(16), .OW(32), .N(8), .HOP(8), .FLUSH_ON_GAP(1'b1), .BITREV(1'b1)) u3(.CLK(clk), .RST_N(rst_n), .bus(b3));
  localparam int CN[4] = '{16, 16, 16, 8};
  localparam int CH[4] = '{16, 8, 16, 8};
  localparam bit CF[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit CB[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int hist[4][$];
  int k[4];
  logic mv[4], movf[4];
  logic [511:0] md[4];
  int total = 0, passed = 0;
  typedef struct { logic [15:0] s; logic [31:0] e; } sx_t;
  sx_t tbl[6];
  int t6[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  function automatic int rev(int w, int n);
    int x = 0;
    for (int m = 1; m < n; m *= 2) x = x * 2 + ((w / m) % 2);
    return x;
  endfunction
  function automatic logic [511:0] seq(int n, int base);
    logic [511:0] f = '0;
    for (int l = 0; l < n; l++) f[l*32 +: 32] = 32'(base + l);
    return f;
  endfunction
  function automatic logic [31:0] ln(int u, int i);
    case (u)
      0: return b0.frm_data[i*32 +: 32];
      1: return b1.frm_data[i*32 +: 32];
      2: return b2.frm_data[i*32 +: 32];
      default: return b3.frm_data[i*32 +: 32];
    endcase
  endfunction
  task automatic chk(string n, logic [511:0] a, logic [511:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
  endtask
  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      hist[j].delete();
      k[j] = 0;
      mv[j] = 1'b0;
      movf[j] = 1'b0;
      md[j] = '0;
    end
  endtask
  // a frame is due when the count of fresh samples reaches N and then every HOP samples after that
  task automatic model_step(logic iv, logic [15:0] id, logic ir, logic icl);
    logic drop, hit;
    logic [511:0] f;
    for (int j = 0; j < 4; j++) begin
      drop = 1'b0;
      hit = 1'b0;
      if (iv) begin
        hist[j].push_back(int'($signed(id)));
        if (hist[j].size() > CN[j]) void'(hist[j].pop_front());
        k[j]++;
        hit = (k[j] >= CN[j]) && ((k[j] - CN[j]) % CH[j] == 0);
      end else if (CF[j]) k[j] = 0;
      if (hit) begin
        f = '0;
        for (int w = 0; w < CN[j]; w++) f[(CB[j] ? rev(w, CN[j]) : w)*32 +: 32] = 32'(hist[j][w]);
        if (!mv[j] || ir) begin
          md[j] = f;
          mv[j] = 1'b1;
        end else drop = 1'b1;
      end else if (mv[j] && ir) mv[j] = 1'b0;
      movf[j] = drop ? 1'b1 : (icl ? 1'b0 : movf[j]);
    end
  endtask
  task automatic check_all();
    chk("d0 valid", 512'(b0.frm_valid), 512'(mv[0]));
    chk("d0 data", b0.frm_data, md[0]);
    chk("d0 ovf", 512'(b0.ovf), 512'(movf[0]));
    chk("d1 valid", 512'(b1.frm_valid), 512'(mv[1]));
    chk("d1 data", b1.frm_data, md[1]);
    chk("d1 ovf", 512'(b1.ovf), 512'(movf[1]));
    chk("d2 valid", 512'(b2.frm_valid), 512'(mv[2]));
    chk("d2 data", b2.frm_data, md[2]);
    chk("d2 ovf", 512'(b2.ovf), 512'(movf[2]));
    chk("d3 valid", 512'(b3.frm_valid), 512'(mv[3]));
    chk("d3 data", 512'(b3.frm_data), md[3]);
    chk("d3 ovf", 512'(b3.ovf), 512'(movf[3]));
  endtask
  task automatic step(logic iv, logic [15:0] id, logic ir, logic icl);
    v = iv;
    d = id;
    r = ir;
    c = icl;
    model_step(iv, id, ir, icl);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {v, d, r, c} = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
    chk("rst valid", 512'(b0.frm_valid), 512'(0));
    chk("rst data", b0.frm_data, 512'(0));
    chk("rst ovf", 512'(b0.ovf), 512'(0));
  endtask
  initial begin
    logic [511:0] e;
    tbl[0] = '{16'h8000, 32'hFFFF8000};
    tbl[1] = '{16'h7FFF, 32'h00007FFF};
    tbl[2] = '{16'hFFFF, 32'hFFFFFFFF};
    tbl[3] = '{16'h0000, 32'h00000000};
    tbl[4] = '{16'h1234, 32'h00001234};
    tbl[5] = '{16'h8001, 32'hFFFF8001};
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0);
      if (i == 15) chk("T1 early", 512'(b0.frm_valid), 512'(0));
    end
    chk("T1 valid", 512'(b0.frm_valid), 512'(1));
    for (int l = 0; l < 16; l++) chk("T1 lane", 512'(ln(0, l)), 512'(l + 1));
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) step(1'b1, i == 3 ? tbl[t].s : 16'(i), 1'b1, 1'b0);
      chk("T2 valid", 512'(b0.frm_valid), 512'(1));
      chk("T2 lane3", 512'(ln(0, 3)), 512'(tbl[t].e));
    end
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0);
      if (i == 16 || i == 24 || i == 32) chk("T3 valid", 512'(b1.frm_valid), 512'(1));
      if (i == 17 || i == 25) chk("T3 gap", 512'(b1.frm_valid), 512'(0));
      if (i == 24) chk("T3 frame2", b1.frm_data, seq(16, 9));
      if (i == 32) chk("T3 frame3", b1.frm_data, seq(16, 17));
    end
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 16'(i), 1'b0, i == 32);
      if (i == 16) chk("T4 no ovf", 512'(b0.ovf), 512'(0));
    end
    chk("T4 held valid", 512'(b0.frm_valid), 512'(1));
    chk("T4 held data", b0.frm_data, seq(16, 1));
    chk("T4 drop beats clr", 512'(b0.ovf), 512'(1));
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("T4 clr", 512'(b0.ovf), 512'(0));
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("T4 accept", 512'(b0.frm_valid), 512'(0));
    chk("T4 data hold", b0.frm_data, seq(16, 1));
    do_reset();
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 16'(100 + i), 1'b1, 1'b0);
      if (i == 6) begin
        e = seq(16, 1);
        for (int l = 10; l < 16; l++) e[l*32 +: 32] = 32'(91 + l);
        chk("T5 pause valid", 512'(b2.frm_valid), 512'(1));
        chk("T5 pause frame", b2.frm_data, e);
        chk("T5 flush early", 512'(b0.frm_valid), 512'(0));
      end
    end
    chk("T5 flush valid", 512'(b0.frm_valid), 512'(1));
    chk("T5 flush frame", b0.frm_data, seq(16, 101));
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    chk("T6 valid", 512'(b3.frm_valid), 512'(1));
    for (int l = 0; l < 8; l++) chk("T6 lane", 512'(ln(3, l)), 512'(t6[l]));
    do_reset();
    for (int i = 1; i <= 21; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 512'(b0.frm_valid), 512'(0));
    chk("mid rst data", b0.frm_data, 512'(0));
    chk("mid rst ovf", 512'(b0.ovf), 512'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 16'(200 + i), 1'b1, 1'b0);
      if (i == 15) chk("post rst early", 512'(b0.frm_valid), 512'(0));
    end
    chk("post rst frame", b0.frm_data, seq(16, 201));
    do_reset();
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 9, 16'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
